pipe_register: RTL and testbench
================================

// Module: pipe_register
// PURPOSE
// - Parametrised elastic pipeline register for the FP datapath; successor to the plain load-enable register.
// - Chain of STAGES registers, each BITS wide, with valid/ready handshake, bubble collapsing and flush.
// - Sits between FP unit stages (unpack -> align -> add/mul -> normalise -> round) so back-pressure and squash propagate cleanly.
// PARAMETERS
// - BITS    32  data width per stage
// - STAGES  3   number of register stages; legal range >= 1
// PORTS
// - clk        in   1                     clock; all state updates on posedge clk
// - reset      in   1                     synchronous, active-high reset
// - flush      in   1                     invalidate every stage; priority over all other inputs
// - in_valid   in   1                     upstream has data on in_data
// - in_ready   out  1                     stage 0 can accept this cycle (combinational)
// - in_data    in   BITS                  upstream data
// - out_valid  out  1                     last stage holds valid data (registered)
// - out_ready  in   1                     downstream accepts out_data this cycle
// - out_data   out  BITS                  last stage data (registered)
// - occupancy  out  $clog2(STAGES+1)      number of valid stages; only with PIPE_REGISTER_OCC_EN
// BEHAVIOUR
// - State: per stage i, v[i] (valid) and d[i] (BITS). Stage STAGES-1 drives out_valid/out_data.
// - Reset (reset=1 at posedge): all v[i]=0, all d[i]=0, so out_valid=0 and out_data=0. occupancy=0.
//   Reset overrides flush and any handshake in the same cycle.
// - Ready chain (combinational):
//   - rdy[STAGES-1] = out_ready | ~v[STAGES-1]
//   - rdy[i] = rdy[i+1] | ~v[i]
//   - in_ready = rdy[0] & ~flush
// - Advance at posedge, when not reset/flush, for each i with rdy[i]=1:
//   - Source valid is in_valid for i=0, v[i-1] otherwise.
//   - v[i] <= source valid.
//   - d[i] <= source data only when source valid=1; otherwise d[i] holds.
// - Hold: stages with rdy[i]=0 keep v[i] and d[i] unchanged.
// - Transfers:
//   - Input transfer: in_valid & in_ready.
//   - Output transfer: out_valid & out_ready.
//   - Data is never duplicated, dropped or reordered.
// - Bubbles: invalid stages collapse. A held stage with empty stages behind it still accepts new data.
// - Latency and throughput: STAGES cycles from input transfer to out_valid when out_ready stays 1.
//   Sustained throughput is 1 word/cycle.
// - Full: all v=1 and out_ready=0 gives in_ready=0. out_ready=1 on a full pipe accepts input in the same cycle.
// - Flush=1 at posedge:
//   - All v <= 0; d is unchanged.
//   - in_ready=0 during the flush cycle, so no input transfer.
//   - out_valid is registered, so an output transfer in the flush cycle still counts (downstream owns that word).
// - Flush released: a new input may be accepted the next cycle; its first out_valid comes STAGES cycles later.
// - STAGES=1: degenerates to a single full-throughput register; in_ready = (out_ready | ~v[0]) & ~flush.
// CONFIGURATION
// - Macro PIPE_REGISTER_OCC_EN.
// - Defined:
//   - The occupancy port exists and counts popcount(v) as a registered value, updated with v.
//   - After reset/flush it reads 0; its maximum value is STAGES.
// - Undefined:
//   - The occupancy port and its counter logic are absent.
//   - All other behaviour is identical.
// TESTING (BITS=32, STAGES=3 unless noted)
// - Reset:
//   - Stimulus: hold reset 2 cycles with in_valid=1, in_data=32'hDEADBEEF.
//   - Response: out_valid=0, out_data=0 and occupancy=0 during reset and 1 cycle after release.
// - Streaming:
//   - Stimulus: out_ready=1; send 32'h3F800000, 32'h40000000, 32'h40400000 on consecutive cycles.
//   - Response: they appear in order on out_data on cycles 3, 4, 5 after the first transfer; in_ready stays 1.
// - Back-pressure:
//   - Stimulus: out_ready=0; offer 4 words 1..4.
//   - Response: words 1..3 accepted; in_ready=0 on word 4; occupancy=3; out_data=1 holds.
//   - Stimulus: raise out_ready.
//   - Response: word 4 is accepted in that same cycle; output order is 1, 2, 3, 4.
// - Bubble collapse:
//   - Stimulus: send word 32'hA, idle 2 cycles, out_ready=0; then send 32'hB, 32'hC.
//   - Response: both are accepted; occupancy=3; output order is A, B, C once out_ready=1.
// - Flush:
//   - Stimulus: pipe full with 5, 6, 7; pulse flush for 1 cycle with in_valid=1, in_data=8.
//   - Response: in_ready=0 that cycle; out_valid=0 on the next cycle; occupancy=0; word 8 never appears.
// - STAGES=1:
//   - Stimulus: alternate out_ready 1/0 while streaming 1..6.
//   - Response: no loss or duplication; latency is 1 cycle; in_ready = out_ready | ~out_valid.

Source files
------------

// File: rtl/pipe_register_if.sv
// rtl/pipe_register_if.sv - handshake bundle between an FP stage and a pipe_register
//
// Purpose: groups the upstream (in_*), downstream (out_*) and flush signals of
//          one pipe_register so FP unit stages can hand a single bundle around.
// Parameter: BITS - data width; must equal the BITS of the attached pipe_register.
// Signals:
//   flush     - invalidate every stage of the attached register
//   in_valid  - upstream has a word on in_data
//   in_ready  - register can accept a word this cycle (combinational)
//   in_data   - upstream word
//   out_valid - last stage holds a valid word (registered)
//   out_ready - downstream takes out_data this cycle
//   out_data  - last stage word (registered)
// Modports:
//   master - the surrounding datapath / controller that drives the register
//   slave  - the pipe_register itself

interface pipe_register_if #(
    parameter int BITS = 32
) ();

    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_data;

    modport master (
        output flush,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/pipe_register.sv
// rtl/pipe_register.sv - elastic multi-stage pipeline register with bubble collapsing and flush
//
// Purpose: chain of STAGES registers, BITS wide each, with a valid/ready
//          handshake. Empty stages collapse so a stalled head does not block
//          new words while there is room behind it. Flush invalidates all
//          stages in one cycle without touching the data registers.
// Parameters:
//   BITS   - data width per stage
//   STAGES - number of register stages (>= 1)
// Ports:
//   clk       - clock, all state changes on its rising edge
//   reset     - synchronous active-high reset; clears valids and data
//   bus       - pipe_register_if.slave: flush, in_valid/in_ready/in_data,
//               out_valid/out_ready/out_data
//   occupancy - registered count of valid stages; present only when the
//               macro PIPE_REGISTER_OCC_EN is defined

module pipe_register #(
    parameter int BITS   = 32,
    parameter int STAGES = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    pipe_register_if.slave                 bus
`ifdef PIPE_REGISTER_OCC_EN
    ,
    output logic [$clog2(STAGES+1)-1:0]    occupancy
`endif
);

    // Per-stage valid flags and data; index STAGES-1 is the output stage.
    logic [STAGES-1:0] v;
    logic [BITS-1:0]   d     [STAGES];

    logic [STAGES-1:0] v_nxt;
    logic [BITS-1:0]   d_nxt [STAGES];

    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] src_v;
    logic [BITS-1:0]   src_d [STAGES];
    logic              all_full;

    // A stage may load when the word ahead of it is leaving or when any stage
    // from here to the output is empty. Written as a running AND of the valid
    // flags from the output backwards so no bit depends on another bit of rdy.
    always_comb begin
        all_full = 1'b1;
        rdy      = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            all_full = all_full & v[i];
            rdy[i]   = bus.out_ready | ~all_full;
        end
    end

    assign bus.in_ready = rdy[0] & ~bus.flush;

    // Each stage loads from the one before it; stage 0 loads from upstream.
    always_comb begin
        src_v    = '0;
        src_d    = '{default: '0};
        src_v[0] = bus.in_valid;
        src_d[0] = bus.in_data;
        for (int i = 1; i < STAGES; i++) begin
            src_v[i] = v[i-1];
            src_d[i] = d[i-1];
        end
    end

    // Data only moves with a valid word so the output stage keeps showing the
    // last delivered word after it drains; flush leaves data untouched.
    always_comb begin
        v_nxt = v;
        d_nxt = d;
        if (bus.flush) begin
            v_nxt = '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v_nxt[i] = src_v[i];
                    if (src_v[i]) begin
                        d_nxt[i] = src_d[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            d <= '{default: '0};
        end else begin
            v <= v_nxt;
            d <= d_nxt;
        end
    end

    assign bus.out_valid = v[STAGES-1];
    assign bus.out_data  = d[STAGES-1];

`ifdef PIPE_REGISTER_OCC_EN
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [OCC_W-1:0] occ_nxt;

    // Counted from the next-state valids so the register tracks v exactly.
    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_register.sv
// tb/tb_pipe_register.sv - self-checking bench for pipe_register (STAGES=3 and STAGES=1)

module tb_pipe_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    always #5 clk = ~clk;

    pipe_register_if #(.BITS(32)) bus3 ();
    pipe_register_if #(.BITS(32)) bus1 ();

    assign bus3.flush     = flush;
    assign bus3.in_valid  = in_valid;
    assign bus3.in_data   = in_data;
    assign bus3.out_ready = out_ready;
    assign bus1.flush     = flush;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.out_ready = out_ready;

`ifdef PIPE_REGISTER_OCC_EN
    logic [1:0] occ3;
    logic [0:0] occ1;
`endif

    pipe_register #(.BITS(32), .STAGES(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
`ifdef PIPE_REGISTER_OCC_EN
        ,
        .occupancy (occ3)
`endif
    );

    pipe_register #(.BITS(32), .STAGES(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
`ifdef PIPE_REGISTER_OCC_EN
        ,
        .occupancy (occ1)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: ordered list of words in flight with their stage
    // position. Each cycle every word moves one stage forward unless the word
    // ahead of it blocks; the oldest leaves when it sits in the last stage and
    // out_ready is high.
    int          m_stages;
    logic [31:0] q_word [$];
    int          q_pos  [$];
    logic [31:0] m_out_data;
    logic [31:0] got    [$];
    logic [31:0] exp_list [$];

    logic        obs_in_ready;
    logic        obs_out_valid;
    logic [31:0] obs_out_data;
    int          obs_occ;
    logic        pre_in_ready;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic sample();
        if (m_stages == 1) begin
            obs_in_ready  = bus1.in_ready;
            obs_out_valid = bus1.out_valid;
            obs_out_data  = bus1.out_data;
`ifdef PIPE_REGISTER_OCC_EN
            obs_occ       = int'(occ1);
`endif
        end else begin
            obs_in_ready  = bus3.in_ready;
            obs_out_valid = bus3.out_valid;
            obs_out_data  = bus3.out_data;
`ifdef PIPE_REGISTER_OCC_EN
            obs_occ       = int'(occ3);
`endif
        end
    endtask

    task automatic model_clear();
        q_word.delete();
        q_pos.delete();
    endtask

    task automatic check_got(input string tag);
        chki({tag, "_count"}, got.size(), exp_list.size());
        for (int i = 0; i < got.size() && i < exp_list.size(); i++) begin
            chk32({tag, "_word"}, got[i], exp_list[i]);
        end
    endtask

    // One clock cycle: drive, check in_ready before the edge, advance the
    // model at the edge, check registered outputs just after it.
    task automatic step(input logic rst_i, input logic fl_i, input logic iv_i,
                        input logic [31:0] id_i, input logic or_i);
        logic exp_rdy;
        logic in_x;
        logic out_x;
        logic exp_ov;
        int   prev;
        int   np;
        reset     = rst_i;
        flush     = fl_i;
        in_valid  = iv_i;
        in_data   = id_i;
        out_ready = or_i;
        #1;
        sample();
        pre_in_ready = obs_in_ready;
        exp_rdy = !fl_i && (or_i || (q_word.size() < m_stages));
        if (!rst_i) begin
            chk1("in_ready", obs_in_ready, exp_rdy);
            if (obs_out_valid === 1'b1 && or_i) got.push_back(obs_out_data);
        end
        @(posedge clk);
        if (rst_i) begin
            model_clear();
            m_out_data = '0;
        end else if (fl_i) begin
            model_clear();
        end else begin
            out_x = (q_word.size() > 0) && (q_pos[0] == m_stages - 1) && or_i;
            in_x  = iv_i && exp_rdy;
            if (out_x) begin
                void'(q_word.pop_front());
                void'(q_pos.pop_front());
            end
            prev = m_stages;
            foreach (q_pos[k]) begin
                np = (q_pos[k] + 1 < prev - 1) ? q_pos[k] + 1 : prev - 1;
                q_pos[k] = np;
                prev = np;
                if (np == m_stages - 1) m_out_data = q_word[k];
            end
            if (in_x) begin
                q_word.push_back(id_i);
                q_pos.push_back(0);
                if (m_stages == 1) m_out_data = id_i;
            end
        end
        #1;
        sample();
        exp_ov = (q_word.size() > 0) && (q_pos[0] == m_stages - 1);
        chk1("out_valid", obs_out_valid, exp_ov);
        chk32("out_data", obs_out_data, m_out_data);
`ifdef PIPE_REGISTER_OCC_EN
        chki("occupancy", obs_occ, q_word.size());
`endif
        @(negedge clk);
    endtask

    initial begin
        int idx;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        m_stages  = 3;
        m_out_data = '0;
        model_clear();

        // Reset held two cycles with a word offered
        step(1, 0, 1, 32'hDEADBEEF, 0);
        step(1, 0, 1, 32'hDEADBEEF, 0);
        step(0, 0, 0, 32'h0, 0);
        chk1("rst_release_out_valid", obs_out_valid, 1'b0);
        chk32("rst_release_out_data", obs_out_data, 32'h0);

        // Streaming at full rate
        got.delete();
        step(0, 0, 1, 32'h3F800000, 1);
        chk1("stream_in_ready0", pre_in_ready, 1'b1);
        step(0, 0, 1, 32'h40000000, 1);
        chk1("stream_in_ready1", pre_in_ready, 1'b1);
        step(0, 0, 1, 32'h40400000, 1);
        chk1("stream_in_ready2", pre_in_ready, 1'b1);
        chk32("stream_cycle3", obs_out_data, 32'h3F800000);
        step(0, 0, 0, 32'h0, 1);
        chk32("stream_cycle4", obs_out_data, 32'h40000000);
        step(0, 0, 0, 32'h0, 1);
        chk32("stream_cycle5", obs_out_data, 32'h40400000);
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        exp_list = '{32'h3F800000, 32'h40000000, 32'h40400000};
        check_got("stream_order");

        // Back-pressure
        got.delete();
        for (int w = 1; w <= 3; w++) begin
            step(0, 0, 1, 32'(w), 0);
            chk1("bp_accept", pre_in_ready, 1'b1);
        end
        step(0, 0, 1, 32'd4, 0);
        chk1("bp_full_in_ready", pre_in_ready, 1'b0);
        chk32("bp_hold_out_data", obs_out_data, 32'd1);
`ifdef PIPE_REGISTER_OCC_EN
        chki("bp_occupancy", obs_occ, 3);
`endif
        step(0, 0, 1, 32'd4, 1);
        chk1("bp_same_cycle_accept", pre_in_ready, 1'b1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 32'h0, 1);
        exp_list = '{32'd1, 32'd2, 32'd3, 32'd4};
        check_got("bp_order");

        // Bubble collapse
        got.delete();
        step(0, 0, 1, 32'hA, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 1, 32'hB, 0);
        chk1("bubble_accept_b", pre_in_ready, 1'b1);
        step(0, 0, 1, 32'hC, 0);
        chk1("bubble_accept_c", pre_in_ready, 1'b1);
        chk32("bubble_head", obs_out_data, 32'hA);
`ifdef PIPE_REGISTER_OCC_EN
        chki("bubble_occupancy", obs_occ, 3);
`endif
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1);
        exp_list = '{32'hA, 32'hB, 32'hC};
        check_got("bubble_order");

        // Flush on a full pipe, then restart
        got.delete();
        step(0, 0, 1, 32'd5, 0);
        step(0, 0, 1, 32'd6, 0);
        step(0, 0, 1, 32'd7, 0);
        step(0, 1, 1, 32'd8, 0);
        chk1("flush_in_ready", pre_in_ready, 1'b0);
        chk1("flush_out_valid", obs_out_valid, 1'b0);
`ifdef PIPE_REGISTER_OCC_EN
        chki("flush_occupancy", obs_occ, 0);
`endif
        step(0, 0, 1, 32'd9, 1);
        chk1("flush_release_accept", pre_in_ready, 1'b1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 1);
        exp_list = '{32'd9};
        check_got("flush_order");

        // Random traffic against the model, STAGES=3
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
        end

        // STAGES=1
        m_stages = 1;
        model_clear();
        step(1, 0, 0, 32'h0, 0);
        got.delete();
        idx = 1;
        for (int c = 0; c < 40 && idx <= 6; c++) begin
            step(0, 0, 1, 32'(idx), (c % 2) == 0);
            if (pre_in_ready === 1'b1) idx++;
        end
        chki("s1_all_sent", idx, 7);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 32'h0, 1);
        exp_list = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        check_got("s1_order");

        // Random traffic against the model, STAGES=1
        for (int c = 0; c < 300; c++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
